// File: rtl/comparator_scheduler_pkg.sv
// Shared types and sizing constants for the comparator scheduler.
package comparator_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int NREQ_DEF = 4;

    function automatic int idw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int IDW_DEF = idw_of(NREQ_DEF);

endpackage

// File: rtl/comparator_scheduler_if.sv
// Request/response bundle between requesters and the scheduler.
interface comparator_scheduler_if
    import comparator_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
);
    localparam int IDW = idw_of(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*8-1:0] req_a;
    logic [NREQ*8-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_equal;
    logic              rsp_greater;
    logic              rsp_less;
    logic              busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id,
        input  rsp_equal, rsp_greater, rsp_less, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id,
        output rsp_equal, rsp_greater, rsp_less, busy
    );

endinterface

// File: rtl/comparator_scheduler_arb.sv
// Combinational round-robin arbiter; pointer state lives in the caller.
module rr_arbiter
    import comparator_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    localparam int IDW = idw_of(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            any
);

    logic found;
    int   idx;

    // Search upward from ptr, wrapping; first hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        any       = |req;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/comparator_scheduler_cmp.sv
// Registered 8-bit unsigned magnitude comparator; no reset on purpose.
module comparator_8bit_clk (
    input  logic       clk,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       equal,
    output logic       greater,
    output logic       less
);

    always_ff @(posedge clk) begin
        equal   <= (a == b);
        greater <= (a > b);
        less    <= (a < b);
    end

endmodule

// File: rtl/comparator_scheduler.sv
// Round-robin front end sharing one registered comparator among requesters.
module comparator_scheduler
    import comparator_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input logic                   clk,
    input logic                   rst,
    comparator_scheduler_if.slave bus
);

    localparam int IDW = idw_of(NREQ);

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  id_q;
    logic [7:0]      a_q;
    logic [7:0]      b_q;
    logic            rsp_valid_q;
    logic            busy_q;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            any;
    logic            take;
    logic [7:0]      sel_a;
    logic [7:0]      sel_b;
    logic            cmp_eq;
    logic            cmp_gt;
    logic            cmp_lt;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (bus.req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    comparator_8bit_clk u_cmp (
        .clk     (clk),
        .a       (a_q),
        .b       (b_q),
        .equal   (cmp_eq),
        .greater (cmp_gt),
        .less    (cmp_lt)
    );

    assign take  = (state == IDLE) && !rst && any;
    assign sel_a = bus.req_a[8*int'(grant_idx) +: 8];
    assign sel_b = bus.req_b[8*int'(grant_idx) +: 8];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (take) begin
                        a_q    <= sel_a;
                        b_q    <= sel_b;
                        id_q   <= grant_idx;
                        ptr    <= (int'(grant_idx) == NREQ - 1)
                                  ? '0 : grant_idx + 1'b1;
                        busy_q <= 1'b1;
                        state  <= CMP;
                    end
                end
                CMP: begin
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    // Comparator output is undefined until first used; gate with valid.
    assign bus.req_ready   = take ? grant : '0;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_id      = id_q;
    assign bus.rsp_equal   = rsp_valid_q & cmp_eq;
    assign bus.rsp_greater = rsp_valid_q & cmp_gt;
    assign bus.rsp_less    = rsp_valid_q & cmp_lt;
    assign bus.busy        = busy_q;

endmodule
